// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//   Groups the sequencer's datapath-facing signals into one bundle.
//   master : the sequencer (consumes clk_en/opcode/flags, drives controls)
//   slave  : the datapath (drives clk_en/opcode/flags, consumes controls)
//   Signals:
//     clk_en, opcode, flag_c, flag_z           datapath -> sequencer
//     pc_inc, pc_load, oe_pc, load_mar, oe_ram,
//     load_ram, load_ir, oe_ir, load_a, oe_a,
//     load_b, alu_sub, oe_alu, load_flags,
//     load_o, halt, step                       sequencer -> datapath
interface control_sequencer_if #(
    parameter int OPCODE_WIDTH = 4
);
    logic                    clk_en;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    flag_c;
    logic                    flag_z;

    logic                    pc_inc;
    logic                    pc_load;
    logic                    oe_pc;
    logic                    load_mar;
    logic                    oe_ram;
    logic                    load_ram;
    logic                    load_ir;
    logic                    oe_ir;
    logic                    load_a;
    logic                    oe_a;
    logic                    load_b;
    logic                    alu_sub;
    logic                    oe_alu;
    logic                    load_flags;
    logic                    load_o;
    logic                    halt;
    logic [2:0]              step;

    modport master (
        input  clk_en, opcode, flag_c, flag_z,
        output pc_inc, pc_load, oe_pc, load_mar, oe_ram, load_ram, load_ir,
               oe_ir, load_a, oe_a, load_b, alu_sub, oe_alu, load_flags,
               load_o, halt, step
    );

    modport slave (
        output clk_en, opcode, flag_c, flag_z,
        input  pc_inc, pc_load, oe_pc, load_mar, oe_ram, load_ram, load_ir,
               oe_ir, load_a, oe_a, load_b, alu_sub, oe_alu, load_flags,
               load_o, halt, step
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
//   Microcoded control unit for the SAP-1.5 computer. Walks fetch/execute
//   micro-steps and produces every bus output-enable and register load.
//   Ports:
//     clk    system clock, posedge
//     reset  asynchronous, active-low
//     bus    control_sequencer_if.master (inputs: clk_en, opcode, flags;
//            outputs: control strobes, halt, step)
//
//   state | meaning
//   T0    | oe_pc -> MAR
//   T1    | RAM -> IR, PC increment
//   T2    | first execute step (operand / jump / out / halt)
//   T3    | second execute step (LDA, ADD, SUB, STA)
//   T4    | ALU writeback (ADD, SUB)
//   halted_q is a separate sticky bit; while set the step is parked at T0.
module control_sequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int MAX_STEP     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    control_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_e;

    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'h1);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'h2);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'h3);
    localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(4'h4);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(4'h5);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(4'h6);
    localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(4'h7);
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(4'h8);
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'hE);
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'hF);

    step_e step_q, step_d;
    logic  halted_q, halted_d;
    logic  active;
    logic  step_legal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        step_d         = step_q;
        halted_d       = halted_q;
        bus.pc_inc     = 1'b0;
        bus.pc_load    = 1'b0;
        bus.oe_pc      = 1'b0;
        bus.load_mar   = 1'b0;
        bus.oe_ram     = 1'b0;
        bus.load_ram   = 1'b0;
        bus.load_ir    = 1'b0;
        bus.oe_ir      = 1'b0;
        bus.load_a     = 1'b0;
        bus.oe_a       = 1'b0;
        bus.load_b     = 1'b0;
        bus.alu_sub    = 1'b0;
        bus.oe_alu     = 1'b0;
        bus.load_flags = 1'b0;
        bus.load_o     = 1'b0;
        bus.halt       = reset & halted_q;
        bus.step       = step_q;

        step_legal = (int'(step_q) <= MAX_STEP);
        // Strobes are gated by reset too, so T0 enables never leak out while
        // the register is being held in reset.
        active     = reset & bus.clk_en & ~halted_q;

        if (active) begin
            if (!step_legal) begin
                step_d = T0;
            end else begin
                case (step_q)
                    T0: begin
                        bus.oe_pc    = 1'b1;
                        bus.load_mar = 1'b1;
                        step_d       = T1;
                    end
                    T1: begin
                        bus.oe_ram  = 1'b1;
                        bus.load_ir = 1'b1;
                        bus.pc_inc  = 1'b1;
                        step_d      = T2;
                    end
                    T2: begin
                        step_d = T0;
                        case (bus.opcode)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                                bus.oe_ir    = 1'b1;
                                bus.load_mar = 1'b1;
                                step_d       = T3;
                            end
                            OP_LDI: begin
                                bus.oe_ir  = 1'b1;
                                bus.load_a = 1'b1;
                            end
                            OP_JMP: begin
                                bus.oe_ir   = 1'b1;
                                bus.pc_load = 1'b1;
                            end
                            OP_JC: begin
                                bus.oe_ir   = bus.flag_c;
                                bus.pc_load = bus.flag_c;
                            end
                            OP_JZ: begin
                                bus.oe_ir   = bus.flag_z;
                                bus.pc_load = bus.flag_z;
                            end
                            OP_OUT: begin
                                bus.oe_a   = 1'b1;
                                bus.load_o = 1'b1;
                            end
                            OP_HLT: begin
                                halted_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    T3: begin
                        step_d = T0;
                        case (bus.opcode)
                            OP_LDA: begin
                                bus.oe_ram = 1'b1;
                                bus.load_a = 1'b1;
                            end
                            OP_ADD, OP_SUB: begin
                                bus.oe_ram = 1'b1;
                                bus.load_b = 1'b1;
                                step_d     = T4;
                            end
                            OP_STA: begin
                                bus.oe_a     = 1'b1;
                                bus.load_ram = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    T4: begin
                        step_d = T0;
                        if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                            bus.oe_alu     = 1'b1;
                            bus.load_a     = 1'b1;
                            bus.load_flags = 1'b1;
                            bus.alu_sub    = (bus.opcode == OP_SUB);
                        end
                    end
                    default: step_d = T0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    localparam logic [14:0] PC_INC  = 15'h4000;
    localparam logic [14:0] PC_LOAD = 15'h2000;
    localparam logic [14:0] OE_PC   = 15'h1000;
    localparam logic [14:0] LD_MAR  = 15'h0800;
    localparam logic [14:0] OE_RAM  = 15'h0400;
    localparam logic [14:0] LD_RAM  = 15'h0200;
    localparam logic [14:0] LD_IR   = 15'h0100;
    localparam logic [14:0] OE_IR   = 15'h0080;
    localparam logic [14:0] LD_A    = 15'h0040;
    localparam logic [14:0] OE_A    = 15'h0020;
    localparam logic [14:0] LD_B    = 15'h0010;
    localparam logic [14:0] ALU_SUB = 15'h0008;
    localparam logic [14:0] OE_ALU  = 15'h0004;
    localparam logic [14:0] LD_FL   = 15'h0002;
    localparam logic [14:0] LD_O    = 15'h0001;
    localparam logic [14:0] NONE    = 15'h0000;

    typedef struct {
        logic [18:0] v;
        string       tag;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    control_sequencer_if sif ();

    control_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] actual();
        return {sif.pc_inc, sif.pc_load, sif.oe_pc, sif.load_mar, sif.oe_ram,
                sif.load_ram, sif.load_ir, sif.oe_ir, sif.load_a, sif.oe_a,
                sif.load_b, sif.alu_sub, sif.oe_alu, sif.load_flags, sif.load_o,
                sif.halt, sif.step};
    endfunction

    // Monitor: every falling edge checks bus contention and, if a vector is
    // pending, compares the DUT's outputs against it.
    always @(negedge clk) begin
        logic [18:0] act;
        int          n_oe;
        exp_t        e;
        act  = actual();
        n_oe = $countones({sif.oe_pc, sif.oe_ram, sif.oe_ir, sif.oe_a, sif.oe_alu});
        checks++;
        if (n_oe > 1) begin
            errors++;
            $display("FAIL bus_contention t=%0t oe_count=%0d required<=1", $time, n_oe);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s t=%0t actual ctl=%h halt=%b step=%0d required ctl=%h halt=%b step=%0d",
                         e.tag, $time, act[18:4], act[3], act[2:0], e.v[18:4], e.v[3], e.v[2:0]);
            end
        end
    end

    task automatic cyc(input logic r, input logic en, input logic [3:0] op,
                       input logic c, input logic z, input logic [14:0] ctl,
                       input logic h, input logic [2:0] st, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset      = r;
        sif.clk_en = en;
        sif.opcode = op;
        sif.flag_c = c;
        sif.flag_z = z;
        e.v   = {ctl, h, st};
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic fetch(input logic [3:0] op, input logic c, input logic z, input string tag);
        cyc(1'b1, 1'b1, op, c, z, OE_PC | LD_MAR, 1'b0, 3'd0, {tag, "_t0"});
        cyc(1'b1, 1'b1, op, c, z, OE_RAM | LD_IR | PC_INC, 1'b0, 3'd1, {tag, "_t1"});
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        sif.clk_en = 1'b0;
        sif.opcode = 4'h0;
        sif.flag_c = 1'b0;
        sif.flag_z = 1'b0;
        #2 reset = 1'b0;

        // reset held low three cycles with clk_en high: everything quiet
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 4'h5, 1'b0, 1'b0, NONE, 1'b0, 3'd0, "reset_hold");

        // LDI then OUT
        fetch(4'h5, 1'b0, 1'b0, "ldi");
        cyc(1'b1, 1'b1, 4'h5, 1'b0, 1'b0, OE_IR | LD_A, 1'b0, 3'd2, "ldi_t2");
        fetch(4'hE, 1'b0, 1'b0, "out");
        cyc(1'b1, 1'b1, 4'hE, 1'b0, 1'b0, OE_A | LD_O, 1'b0, 3'd2, "out_t2");

        // SUB: five steps, alu_sub only in T4
        fetch(4'h3, 1'b0, 1'b0, "sub");
        cyc(1'b1, 1'b1, 4'h3, 1'b0, 1'b0, OE_IR | LD_MAR, 1'b0, 3'd2, "sub_t2");
        cyc(1'b1, 1'b1, 4'h3, 1'b0, 1'b0, OE_RAM | LD_B, 1'b0, 3'd3, "sub_t3");
        cyc(1'b1, 1'b1, 4'h3, 1'b0, 1'b0, OE_ALU | LD_A | LD_FL | ALU_SUB, 1'b0, 3'd4, "sub_t4");

        // JC / JZ, not taken then taken
        fetch(4'h7, 1'b0, 1'b0, "jc0");
        cyc(1'b1, 1'b1, 4'h7, 1'b0, 1'b1, NONE, 1'b0, 3'd2, "jc0_t2");
        fetch(4'h7, 1'b0, 1'b0, "jc1");
        cyc(1'b1, 1'b1, 4'h7, 1'b1, 1'b0, OE_IR | PC_LOAD, 1'b0, 3'd2, "jc1_t2");
        fetch(4'h8, 1'b1, 1'b0, "jz0");
        cyc(1'b1, 1'b1, 4'h8, 1'b1, 1'b0, NONE, 1'b0, 3'd2, "jz0_t2");
        fetch(4'h8, 1'b0, 1'b0, "jz1");
        cyc(1'b1, 1'b1, 4'h8, 1'b0, 1'b1, OE_IR | PC_LOAD, 1'b0, 3'd2, "jz1_t2");

        // LDA, STA, JMP, NOP, undefined opcode
        fetch(4'h1, 1'b0, 1'b0, "lda");
        cyc(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, OE_IR | LD_MAR, 1'b0, 3'd2, "lda_t2");
        cyc(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, OE_RAM | LD_A, 1'b0, 3'd3, "lda_t3");
        fetch(4'h4, 1'b0, 1'b0, "sta");
        cyc(1'b1, 1'b1, 4'h4, 1'b0, 1'b0, OE_IR | LD_MAR, 1'b0, 3'd2, "sta_t2");
        cyc(1'b1, 1'b1, 4'h4, 1'b0, 1'b0, OE_A | LD_RAM, 1'b0, 3'd3, "sta_t3");
        fetch(4'h6, 1'b0, 1'b0, "jmp");
        cyc(1'b1, 1'b1, 4'h6, 1'b0, 1'b0, OE_IR | PC_LOAD, 1'b0, 3'd2, "jmp_t2");
        fetch(4'h0, 1'b0, 1'b0, "nop");
        cyc(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, NONE, 1'b0, 3'd2, "nop_t2");
        fetch(4'hA, 1'b0, 1'b0, "undef");
        cyc(1'b1, 1'b1, 4'hA, 1'b0, 1'b0, NONE, 1'b0, 3'd2, "undef_t2");

        // ADD frozen at T3 for four cycles, then resumes
        fetch(4'h2, 1'b0, 1'b0, "add");
        cyc(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, OE_IR | LD_MAR, 1'b0, 3'd2, "add_t2");
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b0, 4'h2, 1'b0, 1'b0, NONE, 1'b0, 3'd3, "add_frozen");
        cyc(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, OE_RAM | LD_B, 1'b0, 3'd3, "add_t3");
        cyc(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, OE_ALU | LD_A | LD_FL, 1'b0, 3'd4, "add_t4");

        // reset in the middle of ADD aborts it
        fetch(4'h2, 1'b0, 1'b0, "abort");
        cyc(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, OE_IR | LD_MAR, 1'b0, 3'd2, "abort_t2");
        cyc(1'b0, 1'b1, 4'h2, 1'b0, 1'b0, NONE, 1'b0, 3'd0, "abort_reset");
        cyc(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, OE_PC | LD_MAR, 1'b0, 3'd0, "abort_resume_t0");
        cyc(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, OE_RAM | LD_IR | PC_INC, 1'b0, 3'd1, "abort_resume_t1");
        cyc(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, OE_IR | LD_MAR, 1'b0, 3'd2, "abort_resume_t2");
        cyc(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, OE_RAM | LD_B, 1'b0, 3'd3, "abort_resume_t3");
        cyc(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, OE_ALU | LD_A | LD_FL, 1'b0, 3'd4, "abort_resume_t4");

        // HLT: sticky until reset
        fetch(4'hF, 1'b0, 1'b0, "hlt");
        cyc(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, NONE, 1'b0, 3'd2, "hlt_t2");
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 1'b1, 4'(i), 1'b1, 1'b1, NONE, 1'b1, 3'd0, "halted");
        cyc(1'b0, 1'b1, 4'h5, 1'b0, 1'b0, NONE, 1'b0, 3'd0, "halt_reset");
        cyc(1'b1, 1'b1, 4'h5, 1'b0, 1'b0, OE_PC | LD_MAR, 1'b0, 3'd0, "after_halt_t0");

        begin
            int budget;
            budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (exp_q.size() > 0) begin
                errors++;
                $display("FAIL drain pending=%0d required=0", exp_q.size());
            end
        end
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
